jk_mod_counter: RTL and testbench
=================================

JK_MOD_COUNTER -- requirements
Module: jk_mod_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits; every bit is one JK stage.
REQ-002 clk  input  1  single clock, rising-edge active.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  run request, sampled on clk.
REQ-005 en  input  1  count enable in RUN.
REQ-006 up_dn  input  1  direction: 1 = up, 0 = down.
REQ-007 load  input  1  synchronous parallel load.
REQ-008 din  input  WIDTH  load value.
REQ-009 mod_max  input  WIDTH  terminal value; count range 0..mod_max.
REQ-010 oneshot  input  1  1 = stop at terminal, 0 = wrap.
REQ-011 Q  output  WIDTH  count value (registered).
REQ-012 Q_bar  output  WIDTH  bitwise complement of Q.
REQ-013 tc  output  1  terminal-count strobe (combinational).
REQ-014 busy  output  1  high in RUN.
REQ-015 done  output  1  high in DONE.

Function
REQ-016 Each Q bit SHALL update only through JK semantics: Q_next = (J & ~Q) | (~K & Q); count steps use J = K = toggle_i; a load uses J = din_i and K = ~din_i.
REQ-017 The resulting Q SHALL be bit-exact with this arithmetic model:
- Up step: if Q >= mod_max, Q = 0; otherwise Q + 1.
- Down step: if Q == 0, Q = mod_max; otherwise Q - 1.
REQ-018 The FSM SHALL have three states: IDLE, RUN and DONE; busy = (state==RUN) and done = (state==DONE).
REQ-019 IDLE behaviour:
- Q holds.
- start=1 moves to RUN on the next edge.
- Q is not modified by start in IDLE.
REQ-020 RUN behaviour:
- en=0: Q holds.
- en=1: one count step per edge.
REQ-021 Terminal condition: up_dn=1 and Q >= mod_max, or up_dn=0 and Q == 0.
REQ-022 tc SHALL be (state==RUN) & en & terminal condition & ~load.
REQ-023 Terminal step with oneshot=0: Q wraps per REQ-017 and the state stays RUN.
REQ-024 Terminal step with oneshot=1: Q holds its terminal value and the state moves to DONE on the same edge.
REQ-025 DONE behaviour:
- Q holds.
- start=1 moves to RUN and loads Q = 0 (up_dn=1) or Q = mod_max (up_dn=0) on that edge.
REQ-026 load=1 in any state:
- Q = din on the next edge.
- Overrides start and en in that cycle.
- RUN and IDLE keep their state; DONE returns to IDLE.
REQ-027 mod_max == 0:
- Up: Q stays at 0.
- Down: Q stays at 0.
- tc is high on every enabled RUN cycle.
REQ-028 A change of up_dn or mod_max SHALL take effect on the next edge with no extra latency.
REQ-029 Q_bar SHALL equal ~Q at all times, including during reset.

Reset
REQ-030 rst=0 SHALL immediately, independent of clk, force:
- Q = 0 and Q_bar = all ones.
- state = IDLE.
- tc = 0, busy = 0, done = 0.
REQ-031 While rst=0, all inputs SHALL be ignored; after rst rises, the first active edge behaves as IDLE.
REQ-032 Reset asserted mid-count SHALL discard any pending step or load.

Verification (WIDTH=4, mod_max=9)
REQ-033 Up wrap:
- Stimulus: start; en=1, up_dn=1, oneshot=0.
- Response: Q runs 0..9 then 0; tc=1 only in the Q=9 cycle.
REQ-034 Down wrap:
- Stimulus: Q=0, up_dn=0, en=1.
- Response: Q becomes 9, 8, ...; tc=1 in the Q=0 cycle.
REQ-035 Oneshot:
- Stimulus: oneshot=1, count up.
- Response: Q stops at 9 with done=1, busy=0. A following start gives Q=0, busy=1.
REQ-036 Load:
- Stimulus: din=12 with load=1 and start=1 in IDLE.
- Response: Q=12, state IDLE. Then start plus one enabled up step gives Q=0, with tc=1 while Q=12.
- Also: load in DONE returns the FSM to IDLE.
REQ-037 Enable gating: with en toggling 1,0,1 in RUN from Q=3, Q SHALL be 4, 4, 5.
REQ-038 Async reset:
- Stimulus: drop rst between edges at Q=5.
- Response: Q=0 and Q_bar=4'hF before the next edge; busy=0.

Source files
------------

// File: rtl/jk_mod_counter_if.sv
// jk_mod_counter_if -- control and status bundle for jk_mod_counter.
//
// Signals:
//   start    run request (IDLE/DONE -> RUN)
//   en       count enable while running
//   up_dn    direction, 1 = up, 0 = down
//   load     synchronous parallel load of din
//   din      load value
//   mod_max  terminal value; counting range is 0..mod_max
//   oneshot  1 = stop at terminal, 0 = wrap
//   Q        registered count value
//   Q_bar    bitwise complement of Q
//   tc       terminal-count strobe (combinational)
//   busy     counter is in RUN
//   done     counter is in DONE
//
// master: the side that drives control and observes status.
// slave : the counter itself.
interface jk_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] mod_max;
  logic             oneshot;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Q_bar;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output start, en, up_dn, load, din, mod_max, oneshot,
    input  Q, Q_bar, tc, busy, done
  );

  modport slave (
    input  start, en, up_dn, load, din, mod_max, oneshot,
    output Q, Q_bar, tc, busy, done
  );
endinterface

// File: rtl/jk_mod_counter.sv
// jk_mod_counter -- modulo up/down counter built from WIDTH JK stages,
// sequenced by a three-state IDLE/RUN/DONE controller.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-low reset
//   bus  jk_mod_counter_if.slave (control inputs, count and status outputs)
//
// Every Q bit is updated only through the JK characteristic equation
// Q+ = (J & ~Q) | (~K & Q). A count step drives J = K = toggle, where the
// toggle mask is the XOR between the current and the arithmetic target
// value; a load (parallel load, or the restart load out of DONE) drives
// J = value, K = ~value. With neither active, J = K = 0 and the stage holds.
module jk_mod_counter #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  jk_mod_counter_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_load_mode;
  logic             w_step_mode;
  logic             w_term;

  // Terminal condition follows the live direction and mod_max, so a change
  // of either takes effect on the very next edge.
  assign w_term = bus.up_dn ? (r_q >= bus.mod_max) : (r_q == '0);

  always_comb begin
    w_state_next = r_state;
    w_target     = r_q;
    w_load_mode  = 1'b0;
    w_step_mode  = 1'b0;
    if (bus.load) begin
      // Parallel load wins over start and en in every state.
      w_load_mode = 1'b1;
      w_target    = bus.din;
      if (r_state == S_DONE) begin
        w_state_next = S_IDLE;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            w_state_next = S_RUN;
          end
        end
        S_RUN: begin
          if (bus.en) begin
            if (w_term && bus.oneshot) begin
              // Freeze on the terminal value and finish.
              w_state_next = S_DONE;
            end else begin
              w_step_mode = 1'b1;
              if (bus.up_dn) begin
                w_target = w_term ? '0 : (r_q + ONE);
              end else begin
                w_target = w_term ? bus.mod_max : (r_q - ONE);
              end
            end
          end
        end
        S_DONE: begin
          if (bus.start) begin
            // Restart from the beginning of the range for this direction.
            w_state_next = S_RUN;
            w_load_mode  = 1'b1;
            w_target     = bus.up_dn ? '0 : bus.mod_max;
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // One JK stage per bit.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
    logic w_toggle;
    assign w_toggle     = w_step_mode & (w_target[gi] ^ r_q[gi]);
    assign w_j[gi]      = w_load_mode ?  w_target[gi] : w_toggle;
    assign w_k[gi]      = w_load_mode ? ~w_target[gi] : w_toggle;
    assign w_q_next[gi] = (w_j[gi] & ~r_q[gi]) | (~w_k[gi] & r_q[gi]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_q     <= '0;
    end else begin
      r_state <= w_state_next;
      r_q     <= w_q_next;
    end
  end

  assign bus.Q     = r_q;
  assign bus.Q_bar = ~r_q;
  assign bus.busy  = (r_state == S_RUN);
  assign bus.done  = (r_state == S_DONE);
  assign bus.tc    = (r_state == S_RUN) & bus.en & w_term & ~bus.load;

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb_jk_mod_counter -- directed test of jk_mod_counter (WIDTH=4, mod_max=9).
module tb_jk_mod_counter;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  jk_mod_counter_if #(.WIDTH(4)) bus ();

  jk_mod_counter #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %-16s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one active edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.en       = 1'b1;
    bus.up_dn    = 1'b1;
    bus.load     = 1'b1;
    bus.din      = 4'd7;
    bus.mod_max  = 4'd9;
    bus.oneshot  = 1'b0;

    // Reset state, with load held high to show inputs are ignored.
    tick();
    check("rst_q",     32'(bus.Q),     32'h0);
    check("rst_qbar",  32'(bus.Q_bar), 32'hF);
    check("rst_busy",  32'(bus.busy),  32'h0);
    check("rst_done",  32'(bus.done),  32'h0);
    check("rst_tc",    32'(bus.tc),    32'h0);
    bus.load = 1'b0;
    rst      = 1'b1;

    // Up wrap: 0..9 then 0, tc only at 9.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("run_busy",  32'(bus.busy), 32'h1);
    for (int i = 0; i < 10; i++) begin
      check("up_q",    32'(bus.Q),  32'(i));
      check("up_tc",   32'(bus.tc), (i == 9) ? 32'h1 : 32'h0);
      tick();
    end
    check("up_wrap",   32'(bus.Q),  32'h0);

    // Down wrap from 0: tc at 0, then 9, 8.
    bus.up_dn = 1'b0;
    #1;
    check("dn_tc0",    32'(bus.tc), 32'h1);
    tick();
    check("dn_q9",     32'(bus.Q),  32'h9);
    check("dn_tc9",    32'(bus.tc), 32'h0);
    tick();
    check("dn_q8",     32'(bus.Q),  32'h8);

    // Enable gating from Q=3: 4, 4, 5.
    bus.load = 1'b1;
    bus.din  = 4'd3;
    tick();
    bus.load = 1'b0;
    check("ld_run_q",  32'(bus.Q),    32'h3);
    check("ld_run_bsy",32'(bus.busy), 32'h1);
    bus.up_dn = 1'b1;
    tick();
    check("en1_q",     32'(bus.Q),    32'h4);
    bus.en = 1'b0;
    tick();
    check("en0_q",     32'(bus.Q),    32'h4);
    bus.en = 1'b1;
    tick();
    check("en1b_q",    32'(bus.Q),    32'h5);

    // Async reset between edges at Q=5.
    #2;
    rst = 1'b0;
    #1;
    check("arst_q",    32'(bus.Q),     32'h0);
    check("arst_qbar", 32'(bus.Q_bar), 32'hF);
    check("arst_busy", 32'(bus.busy),  32'h0);
    #1;
    rst = 1'b1;
    tick();
    check("post_idle_q",   32'(bus.Q),    32'h0);
    check("post_idle_bsy", 32'(bus.busy), 32'h0);

    // Oneshot up: stop at 9 in DONE, restart to 0.
    bus.oneshot = 1'b1;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("os_q9",     32'(bus.Q),    32'h9);
    check("os_tc",     32'(bus.tc),   32'h1);
    tick();
    check("os_hold",   32'(bus.Q),    32'h9);
    check("os_done",   32'(bus.done), 32'h1);
    check("os_busy",   32'(bus.busy), 32'h0);
    tick();
    check("os_hold2",  32'(bus.Q),    32'h9);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("os_rst_q",  32'(bus.Q),    32'h0);
    check("os_rst_bsy",32'(bus.busy), 32'h1);

    // Oneshot down at 0 -> DONE; start with up_dn=0 restarts at mod_max.
    bus.up_dn = 1'b0;
    tick();
    check("osd_done",  32'(bus.done), 32'h1);
    check("osd_q",     32'(bus.Q),    32'h0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("osd_rst_q", 32'(bus.Q),    32'h9);
    check("osd_busy",  32'(bus.busy), 32'h1);

    // Load in DONE returns to IDLE.
    bus.up_dn = 1'b1;
    tick();
    check("done_again",32'(bus.done), 32'h1);
    bus.load  = 1'b1;
    bus.start = 1'b1;
    bus.din   = 4'd7;
    tick();
    check("ldd_q",     32'(bus.Q),    32'h7);
    check("ldd_done",  32'(bus.done), 32'h0);
    check("ldd_busy",  32'(bus.busy), 32'h0);

    // Load 12 with start in IDLE: stays IDLE; then start + step gives 0.
    bus.din = 4'd12;
    tick();
    bus.load = 1'b0;
    check("ld12_q",    32'(bus.Q),    32'hC);
    check("ld12_busy", 32'(bus.busy), 32'h0);
    tick();
    bus.start   = 1'b0;
    bus.oneshot = 1'b0;
    check("ld12_run_q",32'(bus.Q),    32'hC);
    check("ld12_tc",   32'(bus.tc),   32'h1);
    tick();
    check("ld12_wrap", 32'(bus.Q),    32'h0);
    check("ld12_tc0",  32'(bus.tc),   32'h0);

    // Load suppresses tc even at a terminal value.
    bus.up_dn = 1'b0;
    bus.load  = 1'b1;
    bus.din   = 4'd0;
    #1;
    check("ld_tc_mask",32'(bus.tc),   32'h0);
    tick();
    bus.load = 1'b0;

    // mod_max = 0: Q stays 0 in both directions, tc every enabled cycle.
    bus.mod_max = 4'd0;
    bus.up_dn   = 1'b1;
    #1;
    check("m0_up_tc",  32'(bus.tc),   32'h1);
    tick();
    check("m0_up_q",   32'(bus.Q),    32'h0);
    bus.up_dn = 1'b0;
    #1;
    check("m0_dn_tc",  32'(bus.tc),   32'h1);
    tick();
    check("m0_dn_q",   32'(bus.Q),    32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
